// File: rtl/bsg_dfi_cmd_tracker.sv
// DFI-side DDR command decoder and bank tracker for the DMC emulation path.
// Emits {row, bank, col} commands via a 2-entry FIFO and returns read data at a fixed latency.
module bsg_dfi_cmd_tracker #(
    parameter int unsigned dq_data_width_p = 16,
    parameter int unsigned bank_width_p    = 3,
    parameter int unsigned row_width_p     = 14,
    parameter int unsigned col_width_p     = 10,
    parameter int unsigned rd_lat_p        = 2
) (
    input  logic                                               clk_i,
    input  logic                                               reset_n_i,
    input  logic                                               dfi_cs_n_i,
    input  logic                                               dfi_ras_n_i,
    input  logic                                               dfi_cas_n_i,
    input  logic                                               dfi_we_n_i,
    input  logic [bank_width_p-1:0]                            dfi_bank_i,
    input  logic [15:0]                                        dfi_address_i,
    input  logic                                               dfi_wrdata_en_i,
    input  logic [2*dq_data_width_p-1:0]                       dfi_wrdata_i,
    input  logic [(2*dq_data_width_p/8)-1:0]                   dfi_wrdata_mask_i,
    input  logic                                               dfi_rddata_en_i,
    output logic [2*dq_data_width_p-1:0]                       dfi_rddata_o,
    output logic                                               dfi_rddata_valid_o,
    output logic                                               cmd_v_o,
    output logic                                               cmd_we_o,
    output logic [row_width_p+bank_width_p+col_width_p-1:0]    cmd_addr_o,
    input  logic                                               cmd_ready_i,
    output logic                                               wr_v_o,
    output logic [2*dq_data_width_p-1:0]                       wr_data_o,
    output logic [(2*dq_data_width_p/8)-1:0]                   wr_mask_o,
    input  logic                                               rd_v_i,
    input  logic [2*dq_data_width_p-1:0]                       rd_data_i,
    output logic                                               rd_yumi_o,
    output logic [(1<<bank_width_p)-1:0]                       open_banks_o,
    output logic [15:0]                                        ref_count_o,
    output logic [3:0]                                         error_o
);

    localparam int unsigned data_w    = 2 * dq_data_width_p;
    localparam int unsigned mask_w    = data_w / 8;
    localparam int unsigned num_banks = 1 << bank_width_p;
    localparam int unsigned addr_w    = row_width_p + bank_width_p + col_width_p;
    localparam int unsigned cmd_w     = addr_w + 1;

    // Command decode
    logic is_act_c, is_rd_c, is_wr_c, is_pre_c, is_ref_c, is_rdwr_c;
    logic [2:0] code_c;

    always_comb begin
        code_c   = {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
        is_act_c = 1'b0;
        is_rd_c  = 1'b0;
        is_wr_c  = 1'b0;
        is_pre_c = 1'b0;
        is_ref_c = 1'b0;
        if (!dfi_cs_n_i) begin
            case (code_c)
                3'b011:  is_act_c = 1'b1;
                3'b101:  is_rd_c  = 1'b1;
                3'b100:  is_wr_c  = 1'b1;
                3'b010:  is_pre_c = 1'b1;
                3'b001:  is_ref_c = 1'b1;
                default: ;
            endcase
        end
        is_rdwr_c = is_rd_c | is_wr_c;
    end

    // Bank table
    logic [num_banks-1:0]   open_q, open_d;
    logic [row_width_p-1:0] row_q [num_banks];
    logic                   bank_open_c;

    assign bank_open_c = open_q[dfi_bank_i];

    always_comb begin
        open_d = open_q;
        if (is_act_c) begin
            open_d[dfi_bank_i] = 1'b1;
        end else if (is_pre_c) begin
            if (dfi_address_i[10]) open_d = '0;
            else                   open_d[dfi_bank_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            open_q <= '0;
            for (int i = 0; i < int'(num_banks); i++) row_q[i] <= '0;
        end else begin
            open_q <= open_d;
            if (is_act_c) row_q[dfi_bank_i] <= dfi_address_i[row_width_p-1:0];
        end
    end

    // 2-entry command FIFO; a dequeue frees a slot for a same-cycle enqueue
    logic [cmd_w-1:0] mem_q [2];
    logic             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]       count_q, count_d;
    logic             deq_c, enq_c, full_c;
    logic [cmd_w-1:0] entry_c;

    assign cmd_v_o    = (count_q != 2'd0);
    assign cmd_we_o   = mem_q[rptr_q][cmd_w-1];
    assign cmd_addr_o = mem_q[rptr_q][addr_w-1:0];

    always_comb begin
        full_c  = (count_q == 2'd2);
        deq_c   = cmd_v_o & cmd_ready_i;
        enq_c   = is_rdwr_c & bank_open_c & (~full_c | deq_c);
        entry_c = {is_wr_c, row_q[dfi_bank_i], dfi_bank_i, dfi_address_i[col_width_p-1:0]};
        wptr_d  = enq_c ? ~wptr_q : wptr_q;
        rptr_d  = deq_c ? ~rptr_q : rptr_q;
        count_d = count_q + 2'(enq_c) - 2'(deq_c);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (enq_c) mem_q[wptr_q] <= entry_c;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Read latency pipeline
    logic [rd_lat_p-1:0] rd_pipe_q, rd_pipe_d;
    logic                rd_last_c;
    logic [data_w-1:0]   rddata_q;
    logic                rdvalid_q;

    assign rd_pipe_d = (rd_pipe_q << 1) | rd_lat_p'(dfi_rddata_en_i);
    assign rd_last_c = rd_pipe_q[rd_lat_p-1];
    assign rd_yumi_o = rd_last_c & rd_v_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pipe_q <= '0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            rdvalid_q <= rd_last_c;
            if (rd_last_c) rddata_q <= rd_v_i ? rd_data_i : '0;
        end
    end

    assign dfi_rddata_o       = rddata_q;
    assign dfi_rddata_valid_o = rdvalid_q;

    // Write data passthrough, errors and refresh counter
    logic              wr_v_q;
    logic [data_w-1:0] wr_data_q;
    logic [mask_w-1:0] wr_mask_q;
    logic [15:0]       ref_q;
    logic [3:0]        err_q, err_d;

    always_comb begin
        err_d = err_q | {rd_last_c & ~rd_v_i,
                         is_act_c & bank_open_c,
                         is_rdwr_c & ~bank_open_c,
                         is_rdwr_c & bank_open_c & full_c & ~deq_c};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_v_q    <= 1'b0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            ref_q     <= '0;
            err_q     <= '0;
        end else begin
            wr_v_q    <= dfi_wrdata_en_i;
            wr_data_q <= dfi_wrdata_i;
            wr_mask_q <= dfi_wrdata_mask_i;
            err_q     <= err_d;
            if (is_ref_c) ref_q <= ref_q + 16'd1;
        end
    end

    assign wr_v_o       = wr_v_q;
    assign wr_data_o    = wr_data_q;
    assign wr_mask_o    = wr_mask_q;
    assign open_banks_o = open_q;
    assign ref_count_o  = ref_q;
    assign error_o      = err_q;

    logic unused_addr_c;
    assign unused_addr_c = ^dfi_address_i;

endmodule

// File: tb/tb_bsg_dfi_cmd_tracker.sv
// Scoreboard bench for bsg_dfi_cmd_tracker: commands and read returns are queued when
// driven and compared when the DUT presents them.
module tb_bsg_dfi_cmd_tracker;

    localparam int RD_LAT = 2;
    localparam logic [2:0] OP_ACT = 3'b011, OP_RD = 3'b101, OP_WR = 3'b100,
                           OP_PRE = 3'b010, OP_REF = 3'b001, OP_NOP = 3'b111;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i;
    logic [2:0]  dfi_bank_i;
    logic [15:0] dfi_address_i;
    logic        dfi_wrdata_en_i;
    logic [31:0] dfi_wrdata_i;
    logic [3:0]  dfi_wrdata_mask_i;
    logic        dfi_rddata_en_i;
    logic [31:0] dfi_rddata_o;
    logic        dfi_rddata_valid_o;
    logic        cmd_v_o, cmd_we_o;
    logic [26:0] cmd_addr_o;
    logic        cmd_ready_i;
    logic        wr_v_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_mask_o;
    logic        rd_v_i;
    logic [31:0] rd_data_i;
    logic        rd_yumi_o;
    logic [7:0]  open_banks_o;
    logic [15:0] ref_count_o;
    logic [3:0]  error_o;

    bsg_dfi_cmd_tracker dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .dfi_cs_n_i(dfi_cs_n_i), .dfi_ras_n_i(dfi_ras_n_i),
        .dfi_cas_n_i(dfi_cas_n_i), .dfi_we_n_i(dfi_we_n_i),
        .dfi_bank_i(dfi_bank_i), .dfi_address_i(dfi_address_i),
        .dfi_wrdata_en_i(dfi_wrdata_en_i), .dfi_wrdata_i(dfi_wrdata_i),
        .dfi_wrdata_mask_i(dfi_wrdata_mask_i), .dfi_rddata_en_i(dfi_rddata_en_i),
        .dfi_rddata_o(dfi_rddata_o), .dfi_rddata_valid_o(dfi_rddata_valid_o),
        .cmd_v_o(cmd_v_o), .cmd_we_o(cmd_we_o), .cmd_addr_o(cmd_addr_o),
        .cmd_ready_i(cmd_ready_i), .wr_v_o(wr_v_o), .wr_data_o(wr_data_o),
        .wr_mask_o(wr_mask_o), .rd_v_i(rd_v_i), .rd_data_i(rd_data_i),
        .rd_yumi_o(rd_yumi_o), .open_banks_o(open_banks_o),
        .ref_count_o(ref_count_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;

    logic [27:0] cmdq [$];
    rd_exp_t     rdq [$];
    logic [31:0] pat [2];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          yumi_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [27:0] mk_cmd(input logic we, input logic [13:0] row,
                                           input logic [2:0] bank, input logic [9:0] col);
        return {we, row, bank, col};
    endfunction

    task automatic step();
        @(posedge clk_i);
        cyc++;
        #1;
        rd_data_i = pat[cyc % 2];
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] bank, input logic [15:0] addr);
        dfi_cs_n_i = 1'b0;
        {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i} = op;
        dfi_bank_i = bank;
        dfi_address_i = addr;
        step();
        dfi_cs_n_i = 1'b1;
        {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i} = OP_NOP;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_cmd_v"}, 64'(cmd_v_o), 0);
        check({pfx, "_cmd_addr"}, 64'(cmd_addr_o), 0);
        check({pfx, "_wr_v"}, 64'(wr_v_o), 0);
        check({pfx, "_rd_valid"}, 64'(dfi_rddata_valid_o), 0);
        check({pfx, "_rd_data"}, 64'(dfi_rddata_o), 0);
        check({pfx, "_yumi"}, 64'(rd_yumi_o), 0);
        check({pfx, "_open"}, 64'(open_banks_o), 0);
        check({pfx, "_ref"}, 64'(ref_count_o), 0);
        check({pfx, "_err"}, 64'(error_o), 0);
    endtask

    // Output monitor: compare against queued expectations when the DUT presents data
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            if (cmd_v_o && cmd_ready_i) begin
                if (cmdq.size() == 0) check("cmd_unexpected", 1, 0);
                else check("cmd", 64'({cmd_we_o, cmd_addr_o}), 64'(cmdq.pop_front()));
            end
            if (dfi_rddata_valid_o) begin
                if (rdq.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    rd_exp_t e;
                    e = rdq.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(e.cyc));
                    check("rd_data", 64'(dfi_rddata_o), 64'(e.data));
                end
            end
            if (rd_yumi_o) begin
                yumi_cnt++;
                check("yumi_needs_rd_v", 64'(rd_v_i), 1);
            end
        end
    end

    task automatic rd_pulses(input int n);
        rd_exp_t e;
        for (int k = 0; k < n; k++) begin
            dfi_rddata_en_i = 1'b1;
            e.cyc  = cyc + 1 + RD_LAT;
            e.data = rd_v_i ? pat[(cyc + RD_LAT) % 2] : 32'h0;
            rdq.push_back(e);
            step();
        end
        dfi_rddata_en_i = 1'b0;
        repeat (RD_LAT + 3) step();
        check("rdq_drained", 64'(rdq.size()), 0);
    endtask

    initial begin
        pat[0] = 32'h0000_AAAA;
        pat[1] = 32'h0000_5555;
        reset_n_i = 1'b0;
        dfi_cs_n_i = 1'b1;
        {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i} = OP_NOP;
        dfi_bank_i = '0;
        dfi_address_i = '0;
        dfi_wrdata_en_i = 1'b0;
        dfi_wrdata_i = '0;
        dfi_wrdata_mask_i = '0;
        dfi_rddata_en_i = 1'b0;
        cmd_ready_i = 1'b1;
        rd_v_i = 1'b1;
        rd_data_i = pat[0];

        step();
        step();
        check_zero("reset");
        reset_n_i = 1'b1;
        step();

        // ACT then RD to the same bank
        issue(OP_ACT, 3'd2, 16'h1234);
        check("open_after_act", 64'(open_banks_o), 64'h04);
        cmdq.push_back(mk_cmd(1'b0, 14'h1234, 3'd2, 10'h03F));
        issue(OP_RD, 3'd2, 16'h003F);
        check("cmd_v_after_rd", 64'(cmd_v_o), 1);
        step();
        check("err_clean", 64'(error_o), 0);
        check("cmdq_drained_1", 64'(cmdq.size()), 0);

        // Write data passes through one register
        dfi_wrdata_en_i = 1'b1;
        dfi_wrdata_i = 32'hDEAD_BEEF;
        dfi_wrdata_mask_i = 4'hA;
        step();
        dfi_wrdata_en_i = 1'b0;
        check("wr_v", 64'(wr_v_o), 1);
        check("wr_data", 64'(wr_data_o), 64'hDEAD_BEEF);
        check("wr_mask", 64'(wr_mask_o), 64'hA);
        step();
        check("wr_v_low", 64'(wr_v_o), 0);

        // Overflow: third WR with no dequeue is dropped
        cmd_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) cmdq.push_back(mk_cmd(1'b1, 14'h1234, 3'd2, 10'(i)));
            issue(OP_WR, 3'd2, 16'(i));
        end
        check("err_overflow", 64'(error_o), 64'h1);
        check("cmd_held", 64'({cmd_we_o, cmd_addr_o}), 64'(mk_cmd(1'b1, 14'h1234, 3'd2, 10'd1)));
        cmd_ready_i = 1'b1;
        repeat (3) step();
        check("cmdq_drained_2", 64'(cmdq.size()), 0);
        check("cmd_v_empty", 64'(cmd_v_o), 0);

        // Full FIFO with simultaneous dequeue and enqueue
        cmd_ready_i = 1'b0;
        for (int i = 4; i <= 5; i++) begin
            cmdq.push_back(mk_cmd(1'b1, 14'h1234, 3'd2, 10'(i)));
            issue(OP_WR, 3'd2, 16'(i));
        end
        cmd_ready_i = 1'b1;
        cmdq.push_back(mk_cmd(1'b1, 14'h1234, 3'd2, 10'd6));
        issue(OP_WR, 3'd2, 16'd6);
        cmd_ready_i = 1'b0;
        check("err_no_new_overflow", 64'(error_o), 64'h1);
        check("cmd_v_still", 64'(cmd_v_o), 1);
        cmd_ready_i = 1'b1;
        repeat (3) step();
        check("cmdq_drained_3", 64'(cmdq.size()), 0);

        // Reset with commands in flight
        cmd_ready_i = 1'b0;
        issue(OP_WR, 3'd2, 16'd7);
        issue(OP_WR, 3'd2, 16'd8);
        #2 reset_n_i = 1'b0;
        #1 check("midburst_cmd_v", 64'(cmd_v_o), 0);
        check("midburst_open", 64'(open_banks_o), 0);
        step();
        reset_n_i = 1'b1;
        cmd_ready_i = 1'b1;
        step();
        check("post_reset_err", 64'(error_o), 0);

        // Protocol errors and precharge-all
        issue(OP_RD, 3'd5, 16'h0010);
        check("closed_rd_no_cmd", 64'(cmd_v_o), 0);
        issue(OP_ACT, 3'd2, 16'h0011);
        issue(OP_ACT, 3'd2, 16'h0022);
        issue(OP_PRE, 3'd0, 16'h0400);
        check("err_0110", 64'(error_o), 64'h6);
        check("open_after_pre_all", 64'(open_banks_o), 0);
        check("no_cmd_emitted", 64'(cmd_v_o), 0);

        // Single-bank precharge and row capture
        issue(OP_ACT, 3'd1, 16'h0111);
        issue(OP_ACT, 3'd3, 16'h0333);
        issue(OP_PRE, 3'd1, 16'h0000);
        check("open_after_pre_one", 64'(open_banks_o), 64'h08);
        cmdq.push_back(mk_cmd(1'b0, 14'h0333, 3'd3, 10'h007));
        issue(OP_RD, 3'd3, 16'h0007);
        step();
        check("cmdq_drained_4", 64'(cmdq.size()), 0);

        // Read return with backend data, then with underflow
        rd_v_i = 1'b1;
        yumi_cnt = 0;
        rd_pulses(2);
        check("yumi_count", 64'(yumi_cnt), 2);
        check("err_before_underflow", 64'(error_o), 64'h6);
        rd_v_i = 1'b0;
        rd_pulses(2);
        check("err_underflow", 64'(error_o), 64'hE);
        check("yumi_count_after", 64'(yumi_cnt), 2);
        rd_v_i = 1'b1;

        // Refresh counter wraps
        for (int i = 0; i < 70000; i++) issue(OP_REF, 3'd0, 16'h0000);
        check("ref_wrap", 64'(ref_count_o), 64'd4464);

        // Asynchronous reset mid-activity
        issue(OP_ACT, 3'd0, 16'h0001);
        cmd_ready_i = 1'b0;
        dfi_wrdata_en_i = 1'b1;
        dfi_rddata_en_i = 1'b1;
        issue(OP_RD, 3'd0, 16'h0002);
        dfi_rddata_en_i = 1'b0;
        issue(OP_REF, 3'd0, 16'h0000);
        #3 reset_n_i = 1'b0;
        cmdq.delete();
        rdq.delete();
        #1 check_zero("async_reset");
        dfi_wrdata_en_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        cmd_ready_i = 1'b1;
        repeat (RD_LAT + 2) step();
        check("post_reset_valid", 64'(dfi_rddata_valid_o), 0);
        check("post_reset_cmd_v", 64'(cmd_v_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bsg_dfi_cmd_tracker.md
# bsg_dfi_cmd_tracker

Single-clock, parametrised DFI-side memory emulator front end for the DMC test path. Decodes DDR commands from `bsg_dmc_controller` and tracks the open row per bank. Emits fully formed `{row, bank, col}` read/write commands through a 2-entry buffered ready/valid port, forwards write data, and returns read data at a fixed, parametrised PHY read latency. Adds bank-state tracking, refresh counting and sticky protocol-error reporting for emulation and FPGA bring-up.

## Interface
Parameters:
- `dq_data_width_p`, 16: DQ width; DFI data is `2*dq_data_width_p`, mask is `2*dq_data_width_p/8`.
- `bank_width_p`, 3: bank address bits; `num_banks = 2**bank_width_p`.
- `row_width_p`, 14: row bits taken from `dfi_address_i[row_width_p-1:0]`; legal range 1..16.
- `col_width_p`, 10: column bits taken from `dfi_address_i[col_width_p-1:0]`; legal range 1..10.
- `rd_lat_p`, 2: cycles from `dfi_rddata_en_i` to `dfi_rddata_valid_o`; must be at least 1.

Ports (`addr_w = row_width_p + bank_width_p + col_width_p`):
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous active-low reset.
- `dfi_cs_n_i`, `dfi_ras_n_i`, `dfi_cas_n_i`, `dfi_we_n_i`, in, 1 each: DDR command pins.
- `dfi_bank_i`, in, `bank_width_p`: bank address.
- `dfi_address_i`, in, 16: row/column address; bit 10 is the precharge-all flag.
- `dfi_wrdata_en_i`, in, 1: write data valid.
- `dfi_wrdata_i`, in, 2*dq: write data.
- `dfi_wrdata_mask_i`, in, 2*dq/8: write data mask.
- `dfi_rddata_en_i`, in, 1: read data request.
- `dfi_rddata_o`, out, 2*dq: read data to the controller.
- `dfi_rddata_valid_o`, out, 1: read data valid.
- `cmd_v_o`, out, 1: command valid.
- `cmd_we_o`, out, 1: 1 = write, 0 = read.
- `cmd_addr_o`, out, `addr_w`: `{row, bank, col}`.
- `cmd_ready_i`, in, 1: backend accepts the head command.
- `wr_v_o`, out, 1: write data valid to the backend.
- `wr_data_o`, out, 2*dq: write data to the backend.
- `wr_mask_o`, out, 2*dq/8: write mask to the backend.
- `rd_v_i`, in, 1: backend read data available.
- `rd_data_i`, in, 2*dq: backend read data.
- `rd_yumi_o`, out, 1: consumes the backend read word.
- `open_banks_o`, out, `num_banks`: 1 = bank has an open row.
- `ref_count_o`, out, 16: REF commands seen; wraps modulo 2^16.
- `error_o`, out, 4: sticky flags. [0] command overflow, [1] RD/WR to a closed bank, [2] ACT to an open bank, [3] read underflow.

## Operation
- Decode, only when `cs_n=0`, from `{ras_n, cas_n, we_n}`:
  - 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF.
  - Any other code, or `cs_n=1`, is a NOP.
- Bank table: per bank, an open bit plus a `row_width_p` row register.
- ACT: set the open bit and store the row. If the bank is already open, overwrite the row and set `error_o[2]`.
- PRE: `address[10]=1` clears all open bits; otherwise clears the open bit of `dfi_bank_i` only. PRE to a closed bank is legal.
- REF: increments `ref_count_o`. Bank state is unchanged.
- RD/WR to an open bank: enqueue `{we, stored row, bank, col}` into the 2-entry command FIFO.
- RD/WR to a closed bank: dropped; set `error_o[1]`.
- Command FIFO full when RD/WR arrives and no dequeue happens that cycle: command dropped; set `error_o[0]`.
- Simultaneous dequeue (`cmd_v_o & cmd_ready_i`) and enqueue while full: both succeed; count stays 2.
- Write path: `wr_v_o`, `wr_data_o` and `wr_mask_o` are `dfi_wrdata_*` delayed one register. There is no backpressure.
- Read path: `dfi_rddata_en_i` enters an `rd_lat_p`-stage valid shift pipeline. When a 1 reaches the last stage:
  - `rd_yumi_o = rd_v_i`.
  - The output register loads `rd_data_i`, or 0 if `rd_v_i=0`, in which case `error_o[3]` is set.
  - `dfi_rddata_valid_o=1` on the following cycle.
- Error flags stick until reset.

## Timing
- Reset, asynchronous on `reset_n_i=0`:
  - Every output is 0: `cmd_v_o`, `wr_v_o`, `dfi_rddata_valid_o`, `dfi_rddata_o`, `rd_yumi_o`, `open_banks_o`, `ref_count_o`, `error_o`.
  - FIFO, pipeline and bank table are cleared.
  - Reset mid-burst discards all in-flight commands and reads.
- Command latency: RD/WR sampled at edge N gives `cmd_v_o=1` after edge N. FIFO registers only; there is no combinational input-to-`cmd_v_o` path.
- `cmd_*_o` is held stable while `cmd_v_o & ~cmd_ready_i`. Full throughput is 1 command per cycle.
- `open_banks_o` updates one edge after ACT/PRE. A RD in the cycle immediately after an ACT sees the bank open.
- Read latency: `dfi_rddata_en_i` high at edge N gives `dfi_rddata_valid_o` high for exactly the cycle after edge N+`rd_lat_p`. Back-to-back enables give back-to-back valids.
- `rd_yumi_o` is combinational from the last pipeline stage and `rd_v_i`, and is only ever high when `rd_v_i` is high.
- Write data is delayed 1 cycle.

## Test plan
- ACT bank 2 row 0x1234, then RD bank 2 col 0x3F, with `cmd_ready_i=1`:
  - `open_banks_o=0x04`.
  - `cmd_v_o` one cycle after the RD, with `cmd_we_o=0` and `cmd_addr_o={0x1234, 2, 0x3F}`.
  - `error_o=0`.
- With `cmd_ready_i=0`, issue 3 WRs to an open bank:
  - The first two are buffered.
  - The third sets `error_o[0]`.
  - Raising `cmd_ready_i` drains exactly 2 commands in order.
- With the FIFO full, a WR arrives in the same cycle as a dequeue: accepted, no error, FIFO count stays 2.
- Sequence RD to closed bank 5, ACT to open bank 2, then PRE with `address[10]=1`:
  - `error_o=0b0110`, and no command is emitted.
  - After the PRE, `open_banks_o=0`.
- `rd_lat_p=2`, `rddata_en` pulses at cycles 10 and 11:
  - With `rd_v_i=1` and data 0xAAAA then 0x5555: valid at cycles 13 and 14, with matching data.
  - Repeat with `rd_v_i=0`: `dfi_rddata_o=0` and `error_o[3]=1`.
- 70000 REF commands: `ref_count_o=4464` (wrapped). Assert reset mid-run: all outputs 0 immediately.
